pkt_readout_ctrl: RTL and testbench
===================================

# pkt_readout_ctrl

Read-side sequencer for the packet buffer that the frame receiver path fills. It pops frame lengths from the length FIFO and walks the byte memory from a wrapping read pointer. The read bytes go out as a GMII-style transmit stream (`o_tx_dv`/`o_tx_data`), with an enforced inter-frame gap between frames. It is the block that drains stored frames back out, e.g. to a transmitter or to the test stream checker.

## Interface
- `pADDR_W`, 14, byte-memory address width; read pointer wraps modulo 2^pADDR_W
- `pLEN_W`, 11, width of a length-FIFO entry, in bytes
- `pIFG`, 12, idle cycles forced between the last `o_tx_dv` of one frame and the next `o_fifo_rd`; minimum 1
- `iclk`  in  1  sole clock; all logic on posedge
- `i_rst_n`  in  1  asynchronous, active-low reset
- `i_fifo_empty`  in  1  length FIFO empty
- `i_fifo_len`  in  pLEN_W  head entry of the length FIFO (first-word-fall-through), valid when `!i_fifo_empty`
- `o_fifo_rd`  out  1  one-cycle pop strobe
- `o_mem_rd`  out  1  memory read enable
- `o_mem_addr`  out  pADDR_W  memory byte address
- `i_mem_data`  in  8  memory read data, valid exactly 1 cycle after `o_mem_rd`
- `i_pause`  in  1  blocks starting a new frame; ignored once a frame has started
- `o_tx_dv`  out  1  output byte valid; contiguous for the whole frame
- `o_tx_data`  out  8  output byte
- `o_busy`  out  1  high in any state other than IDLE
- `o_drop`  out  1  one-cycle pulse when a zero-length entry is popped
- `o_frame_cnt`  out  16  frames emitted; wraps at 2^16

## Operation
- States: IDLE, READ, DRAIN, GAP.
- IDLE, when `!i_fifo_empty && !i_pause` at an edge:
  - latch `len <= i_fifo_len` and register `o_fifo_rd = 1` for the next cycle.
  - If len == 0: pulse `o_drop`, go to GAP. The pointer does not move.
  - Otherwise go to READ with `remain = len`.
- READ:
  - `o_mem_rd = 1`, `o_mem_addr = rd_ptr`.
  - Each cycle, `rd_ptr <= rd_ptr + 1` (mod 2^pADDR_W) and `remain <= remain - 1`.
  - Exit to DRAIN after the cycle in which `remain == 1`.
- Data pipeline: `o_tx_dv`/`o_tx_data` are registered copies of a 1-cycle-delayed `o_mem_rd` and of `i_mem_data`. The output lags `o_mem_rd` by 2 cycles.
- DRAIN: wait until the last byte has been presented on `o_tx_dv`. At that point increment `o_frame_cnt` and go to GAP.
- GAP: count pIFG cycles with `o_tx_dv = 0`, then go to IDLE.
- `rd_ptr` persists across frames. Frames are stored back-to-back, so a frame may straddle the wrap point; it is read across the wrap without a break.
- `i_pause` asserted during READ, DRAIN or GAP has no effect on the current frame.

## Timing
- Reset (async assert, sync release): state IDLE, `rd_ptr = 0`, `remain = 0`, gap counter 0. All outputs are 0, including `o_mem_addr`, `o_tx_data` and `o_frame_cnt`.
- Reset mid-frame: the output stream stops immediately and no partial-frame count is kept. The FIFO entry already popped is lost.
- Edge E samples a start condition. Then:
  - cycle E+1: `o_fifo_rd = 1` and the first `o_mem_rd`.
  - cycles E+1..E+len: `o_mem_rd` high.
  - cycles E+3..E+len+2: `o_tx_dv` high.
- The next `o_fifo_rd` is no earlier than cycle E+len+3+pIFG.
- `o_fifo_rd` is never high for two consecutive cycles. It is never asserted while `i_fifo_empty` was sampled high.
- Maximum len = 2^pLEN_W − 1. `remain` is pLEN_W bits wide; no overflow is possible.

## Configuration
- `PKT_RD_CRC_STRIP_EN` defined: the final 4 bytes of each frame (the FCS) are suppressed.
  - READ still fetches all len bytes, and `rd_ptr` advances by len.
  - `o_tx_dv` covers only the first len−4 bytes.
  - Frames with len ≤ 4 emit no `o_tx_dv`, are not counted in `o_frame_cnt`, and pulse `o_drop`.
- Undefined: every stored byte, FCS included, is emitted.

## Test plan
- Single 64-byte frame at `rd_ptr = 0`, memory pattern = address[7:0] → `o_tx_dv` is high for 64 contiguous cycles starting at E+3, bytes 0x00..0x3F, and `o_frame_cnt = 1`.
- Two queued frames of 60 and 100 bytes, pIFG = 12 → exactly 12 idle cycles between the bursts. The second frame starts at address 60.
- Wrap: `rd_ptr` preloaded by draining frames up to 16380, then a 10-byte frame → addresses 16380..16383 then 0..5, with no gap in `o_tx_dv`.
- Zero-length entry followed by a 1-byte entry → `o_drop` pulses once, followed by a single 1-cycle `o_tx_dv`; `rd_ptr` ends at 1.
- `i_pause` high with FIFO non-empty, then low; pause re-asserted mid-frame → nothing starts while paused; once started, the frame completes fully.
- `i_rst_n` pulsed low for 1 cycle during byte 20 of a 64-byte frame → all outputs 0 on the same edge; the next frame is read from address 0.
- With `PKT_RD_CRC_STRIP_EN`: a 64-byte frame → 60 bytes on `o_tx_dv`, `rd_ptr` ends at 64. A 4-byte frame → no output and one `o_drop` pulse.

Source files
------------

// File: rtl/pkt_readout_ctrl.sv
// Read-side sequencer: pops frame lengths, walks the byte memory from a wrapping pointer and
// emits a GMII-style tx stream with a forced inter-frame gap. Define PKT_RD_CRC_STRIP_EN to drop FCS.
module pkt_readout_ctrl #(
  parameter int unsigned pADDR_W = 14,
  parameter int unsigned pLEN_W  = 11,
  parameter int unsigned pIFG    = 12
) (
  input  logic               iclk,
  input  logic               i_rst_n,
  input  logic               i_fifo_empty,
  input  logic [pLEN_W-1:0]  i_fifo_len,
  output logic               o_fifo_rd,
  output logic               o_mem_rd,
  output logic [pADDR_W-1:0] o_mem_addr,
  input  logic [7:0]         i_mem_data,
  input  logic               i_pause,
  output logic               o_tx_dv,
  output logic [7:0]         o_tx_data,
  output logic               o_busy,
  output logic               o_drop,
  output logic [15:0]        o_frame_cnt
);

`ifdef PKT_RD_CRC_STRIP_EN
  localparam bit StripEn = 1'b1;
`else
  localparam bit StripEn = 1'b0;
`endif

  // Gap counter must hold pIFG + 1 for the zero-length case.
  localparam int unsigned GapW = $clog2(pIFG + 2);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StGap} state_e;

  state_e             state_q, state_d;
  logic [pADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [pLEN_W-1:0]  remain_q, remain_d;
  logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               fifo_rd_q, fifo_rd_d;
  logic               drop_q, drop_d;
  logic               short_q, short_d;
  logic               rd_d1_q, dv_d1_q, tx_dv_q;
  logic [7:0]         tx_data_q;

  logic start, gap_done, pop, emit, count_ok;

  assign start    = !i_fifo_empty && !i_pause;
  assign gap_done = (gap_cnt_q == '0);
  // The final gap cycle doubles as the sampling cycle, so frames are exactly pIFG idle apart.
  assign pop      = start && ((state_q == StIdle) || ((state_q == StGap) && gap_done));
  assign emit     = !StripEn || (remain_q > pLEN_W'(4));
  assign count_ok = !(StripEn && short_q);

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    remain_d    = remain_q;
    gap_cnt_d   = gap_cnt_q;
    frame_cnt_d = frame_cnt_q;
    short_d     = short_q;
    fifo_rd_d   = 1'b0;
    drop_d      = 1'b0;

    unique case (state_q)
      StIdle: ;
      StRead: begin
        rd_ptr_d = rd_ptr_q + pADDR_W'(1);
        remain_d = remain_q - pLEN_W'(1);
        if (remain_q == pLEN_W'(1)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Last fetch has left stage 1, so the final byte is on the output this cycle.
        if (!rd_d1_q) begin
          if (count_ok) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
          gap_cnt_d = GapW'(pIFG - 1);
          state_d   = StGap;
        end
      end
      StGap: begin
        if (gap_done) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (pop) begin
      fifo_rd_d = 1'b1;
      remain_d  = i_fifo_len;
      short_d   = (i_fifo_len <= pLEN_W'(4));
      if (i_fifo_len == '0) begin
        // Two extra gap cycles keep the same pop spacing as a frame that went through READ.
        drop_d    = 1'b1;
        gap_cnt_d = GapW'(pIFG + 1);
        state_d   = StGap;
      end else begin
        drop_d  = StripEn && (i_fifo_len <= pLEN_W'(4));
        state_d = StRead;
      end
    end
  end

  always_ff @(posedge iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      rd_ptr_q    <= '0;
      remain_q    <= '0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= '0;
      short_q     <= 1'b0;
      fifo_rd_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      remain_q    <= remain_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      short_q     <= short_d;
      fifo_rd_q   <= fifo_rd_d;
      drop_q      <= drop_d;
    end
  end

  // Stage 1 aligns with memory read latency; stage 2 registers the outgoing byte.
  always_ff @(posedge iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_d1_q   <= 1'b0;
      dv_d1_q   <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      rd_d1_q   <= o_mem_rd;
      dv_d1_q   <= o_mem_rd && emit;
      tx_dv_q   <= dv_d1_q;
      tx_data_q <= dv_d1_q ? i_mem_data : 8'h00;
    end
  end

  assign o_fifo_rd   = fifo_rd_q;
  assign o_drop      = drop_q;
  assign o_mem_rd    = (state_q == StRead);
  assign o_mem_addr  = rd_ptr_q;
  assign o_tx_dv     = tx_dv_q;
  assign o_tx_data   = tx_data_q;
  assign o_busy      = (state_q != StIdle);
  assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_pkt_readout_ctrl.sv
// Directed bench for pkt_readout_ctrl: FIFO and byte-memory models, negedge monitor, immediate
// assertions against hand-derived expectations.
module tb_pkt_readout_ctrl;
  localparam int unsigned AddrW = 14;
  localparam int unsigned LenW  = 11;
  localparam int unsigned Ifg   = 12;
`ifdef PKT_RD_CRC_STRIP_EN
  localparam bit Strip = 1'b1;
`else
  localparam bit Strip = 1'b0;
`endif

  logic             iclk    = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             pause   = 1'b0;
  logic [7:0]       mem_data = 8'h00;
  logic             fifo_empty;
  logic [LenW-1:0]  fifo_len;
  logic             fifo_rd, mem_rd, tx_dv, busy, drop;
  logic [AddrW-1:0] mem_addr;
  logic [7:0]       tx_data;
  logic [15:0]      frame_cnt;

  pkt_readout_ctrl #(.pADDR_W(AddrW), .pLEN_W(LenW), .pIFG(Ifg)) dut (
    .iclk        (iclk),
    .i_rst_n     (i_rst_n),
    .i_fifo_empty(fifo_empty),
    .i_fifo_len  (fifo_len),
    .o_fifo_rd   (fifo_rd),
    .o_mem_rd    (mem_rd),
    .o_mem_addr  (mem_addr),
    .i_mem_data  (mem_data),
    .i_pause     (pause),
    .o_tx_dv     (tx_dv),
    .o_tx_data   (tx_data),
    .o_busy      (busy),
    .o_drop      (drop),
    .o_frame_cnt (frame_cnt)
  );

  always #5 iclk = ~iclk;

  // Length FIFO (first-word-fall-through) and byte memory holding address[7:0].
  logic [LenW-1:0] fmem [16];
  int fwr = 0;
  int frd = 0;
  assign fifo_empty = (fwr == frd);
  assign fifo_len   = fmem[frd[3:0]];

  int cyc = 0;
  always @(posedge iclk) begin
    cyc      <= cyc + 1;
    mem_data <= mem_addr[7:0];
    if (fifo_rd) frd <= frd + 1;
  end

  int   rd_cyc[$], ma[$], ma_cyc[$], dv_cyc[$], dv_dat[$], drop_cyc[$];
  int   proto_bad  = 0;
  logic prev_rd    = 1'b0;
  logic prev_empty = 1'b1;

  always @(negedge iclk) begin
    if (fifo_rd) begin
      rd_cyc.push_back(cyc);
      if (prev_rd || prev_empty) proto_bad++;
    end
    if (mem_rd) begin
      ma.push_back(int'(mem_addr));
      ma_cyc.push_back(cyc);
    end
    if (tx_dv) begin
      dv_cyc.push_back(cyc);
      dv_dat.push_back(int'(tx_data));
    end
    if (drop) drop_cyc.push_back(cyc);
    prev_rd    = fifo_rd;
    prev_empty = fifo_empty;
  end

  int n_pass = 0;
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge iclk);
    #1;
  endtask

  task automatic push(input int len);
    fmem[fwr[3:0]] = LenW'(len);
    fwr++;
  endtask

  task automatic clear_log();
    rd_cyc.delete(); ma.delete(); ma_cyc.delete();
    dv_cyc.delete(); dv_dat.delete(); drop_cyc.delete();
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    tick(2);
    i_rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    tick(1);
    while ((busy || fwr != frd) && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, int'(n < budget), 1);
  endtask

  function automatic int olen(input int len);
    if (!Strip) return len;
    return (len > 4) ? len - 4 : 0;
  endfunction

  function automatic int bad_bytes(input int base);
    int b = 0;
    for (int i = 0; i < dv_dat.size(); i++) begin
      if (dv_dat[i] != ((base + i) % 256)) b++;
    end
    return b;
  endfunction

  int n, fc0;

  initial begin
    // Reset state
    tick(3);
    chk("rst_fifo_rd", int'(fifo_rd), 0);
    chk("rst_mem_rd", int'(mem_rd), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_tx_dv", int'(tx_dv), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_drop", int'(drop), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    i_rst_n = 1'b1;
    tick(2);

    // Single 64-byte frame from address 0
    clear_log();
    push(64);
    wait_done("f64_done", 200);
    chk("f64_pops", rd_cyc.size(), 1);
    chk("f64_mem_reads", ma.size(), 64);
    chk("f64_first_addr", ma[0], 0);
    chk("f64_last_addr", ma[63], 63);
    chk("f64_memrd_start", ma_cyc[0] - rd_cyc[0], 0);
    chk("f64_dv_len", dv_cyc.size(), olen(64));
    chk("f64_dv_latency", dv_cyc[0] - rd_cyc[0], 2);
    chk("f64_dv_contig", dv_cyc[dv_cyc.size()-1] - dv_cyc[0], olen(64) - 1);
    chk("f64_bytes", bad_bytes(0), 0);
    chk("f64_last_byte", dv_dat[dv_dat.size()-1], olen(64) - 1);
    chk("f64_frame_cnt", int'(frame_cnt), 1);
    chk("f64_no_drop", drop_cyc.size(), 0);

    // Two queued frames, 60 and 100 bytes
    do_reset();
    clear_log();
    push(60);
    push(100);
    wait_done("f2_done", 400);
    chk("f2_pops", rd_cyc.size(), 2);
    chk("f2_pop_spacing", rd_cyc[1] - rd_cyc[0], 60 + 2 + Ifg);
    chk("f2_ifg_idle", rd_cyc[1] - (ma_cyc[59] + 2) - 1, Ifg);
    chk("f2_second_addr", ma[60], 60);
    chk("f2_mem_reads", ma.size(), 160);
    chk("f2_dv_total", dv_cyc.size(), olen(60) + olen(100));
    chk("f2_second_byte0", dv_dat[olen(60)], 60);
    chk("f2_frame_cnt", int'(frame_cnt), 2);

    // Preload pointer to 16380, then a frame that straddles the wrap
    do_reset();
    for (int i = 0; i < 8; i++) push(2047);
    push(4);
    wait_done("pre_done", 20000);
    chk("pre_frame_cnt", int'(frame_cnt), Strip ? 8 : 9);
    clear_log();
    fc0 = int'(frame_cnt);
    push(10);
    wait_done("wrap_done", 200);
    chk("wrap_reads", ma.size(), 10);
    chk("wrap_addr0", ma[0], 16380);
    chk("wrap_addr3", ma[3], 16383);
    chk("wrap_addr4", ma[4], 0);
    chk("wrap_addr9", ma[9], 5);
    chk("wrap_memrd_contig", ma_cyc[9] - ma_cyc[0], 9);
    chk("wrap_dv_len", dv_cyc.size(), olen(10));
    chk("wrap_dv_contig", dv_cyc[dv_cyc.size()-1] - dv_cyc[0], olen(10) - 1);
    chk("wrap_bytes", bad_bytes(16380), 0);
    chk("wrap_frame_cnt", int'(frame_cnt) - fc0, 1);

    // Zero-length entry then a 1-byte entry
    do_reset();
    clear_log();
    push(0);
    push(1);
    wait_done("zero_done", 200);
    chk("zero_drops", drop_cyc.size(), Strip ? 2 : 1);
    chk("zero_drop_cycle", drop_cyc[0], rd_cyc[0]);
    chk("zero_pop_spacing", rd_cyc[1] - rd_cyc[0], Ifg + 2);
    chk("zero_reads", ma.size(), 1);
    chk("zero_read_addr", ma[0], 0);
    chk("zero_dv_len", dv_cyc.size(), olen(1));
    chk("zero_frame_cnt", int'(frame_cnt), Strip ? 0 : 1);
    clear_log();
    push(3);
    wait_done("after_zero_done", 200);
    chk("after_zero_addr", ma[0], 1);

    // Pause before a start, then re-asserted mid-frame
    clear_log();
    fc0   = int'(frame_cnt);
    pause = 1'b1;
    push(5);
    tick(20);
    chk("pause_no_pop", rd_cyc.size(), 0);
    chk("pause_idle", int'(busy), 0);
    pause = 1'b0;
    n = 0;
    while (rd_cyc.size() == 0 && n < 10) begin
      tick(1);
      n++;
    end
    chk("unpause_pop", rd_cyc.size(), 1);
    pause = 1'b1;
    push(7);
    tick(40);
    chk("pause_frame_reads", ma.size(), 5);
    chk("pause_frame_addr", ma[0], 4);
    chk("pause_frame_dv", dv_cyc.size(), olen(5));
    chk("pause_frame_cnt", int'(frame_cnt) - fc0, 1);
    chk("pause_held", rd_cyc.size(), 1);
    pause = 1'b0;
    wait_done("pause_release_done", 200);
    chk("pause_release_pops", rd_cyc.size(), 2);
    chk("pause_release_reads", ma.size(), 12);

    // Reset pulse while byte 20 of a 64-byte frame is on the output
    clear_log();
    push(64);
    n = 0;
    while (dv_dat.size() < 20 && n < 200) begin
      tick(1);
      n++;
    end
    chk("mid_reach_byte20", dv_dat.size(), 20);
    chk("mid_dv_before", int'(tx_dv), 1);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_dv", int'(tx_dv), 0);
    chk("mid_rst_data", int'(tx_data), 0);
    chk("mid_rst_mem_rd", int'(mem_rd), 0);
    chk("mid_rst_addr", int'(mem_addr), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_cnt", int'(frame_cnt), 0);
    @(posedge iclk);
    #1;
    i_rst_n = 1'b1;
    tick(1);
    clear_log();
    push(8);
    wait_done("mid_next_done", 200);
    chk("mid_next_addr", ma[0], 0);
    chk("mid_next_dv", dv_cyc.size(), olen(8));
    chk("mid_next_cnt", int'(frame_cnt), 1);

    chk("fifo_rd_protocol", proto_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
